// File: rtl/fix2flt_seq_if.sv
// fix2flt_seq_if: start/done control bus of the fixed-to-half converter.
//   start   : request; sampled by the converter only while idle
//   fix_in  : operand {sign, 15-bit magnitude}, captured on the accepting edge
//   busy    : converter is working on an operand
//   done    : one-cycle pulse, flt_out valid
//   flt_out : binary16 result, held until the next conversion completes
interface fix2flt_seq_if;
  logic        start;
  logic [15:0] fix_in;
  logic        busy;
  logic        done;
  logic [15:0] flt_out;

  modport master (output start, fix_in, input busy, done, flt_out);
  modport slave  (input start, fix_in, output busy, done, flt_out);
endinterface

// File: rtl/fix2flt_seq.sv
// fix2flt_seq: sequential sign-and-magnitude fixed point to IEEE-754 binary16.
// The magnitude is normalised one bit per cycle by left shifts until bit 14
// holds the leading one; the shift count then sets the exponent and the bits
// just below the leading one form the (truncated) mantissa.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : slave side of fix2flt_seq_if (start/fix_in in, busy/done/flt_out out)
module fix2flt_seq #(
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic          clk,
  input  logic          reset,
  fix2flt_seq_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_PACK} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_sgn;
  logic [14:0] r_mag;
  logic [3:0]  r_cnt;
  logic [15:0] r_flt;
  logic        r_done;
  logic [5:0]  w_exp;

  // Leading one at bit 14 after r_cnt shifts means value = 1.x * 2^(14-FRAC_BITS-r_cnt);
  // adding the bias of 15 gives 29 - FRAC_BITS - r_cnt.
  assign w_exp = 6'd29 - 6'(FRAC_BITS) - {2'b00, r_cnt};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next = (bus.fix_in[14:0] == '0) ? S_PACK : S_NORM;
      S_NORM: if (r_mag[14]) w_next = S_PACK;
      S_PACK: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sgn  <= 1'b0;
      r_mag  <= '0;
      r_cnt  <= '0;
      r_flt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_sgn <= bus.fix_in[15];
            r_mag <= bus.fix_in[14:0];
            r_cnt <= '0;
          end
        end
        S_NORM: begin
          if (!r_mag[14]) begin
            r_mag <= r_mag << 1;
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_PACK: begin
          r_done <= 1'b1;
          // Zero keeps its sign so -0 survives the conversion.
          if (r_mag == '0) r_flt <= {r_sgn, 15'b0};
          else             r_flt <= {r_sgn, w_exp[4:0], r_mag[13:4]};
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;
  assign bus.flt_out = r_flt;

endmodule

// File: tb/tb_fix2flt_seq.sv
module tb_fix2flt_seq;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  fix2flt_seq_if bus ();

  fix2flt_seq #(.FRAC_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one conversion: start for a single edge, then scrambles fix_in while
  // busy. lat counts edges from the accepting edge (1) to the done edge.
  task automatic convert(input logic [15:0] v, output logic [15:0] res,
                         output int lat, output int bcyc, output bit tmo);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.fix_in = v;
    @(posedge clk); #1;
    lat  = 1;
    bcyc = bus.busy ? 1 : 0;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.fix_in = 16'hA5A5;
    tmo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) begin
        tmo = 1'b0;
        break;
      end
      if (bus.busy) bcyc++;
    end
    res = bus.flt_out;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.start  = 1'b0;
    bus.fix_in = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
    tests++; if (bus.flt_out !== 16'h0000) begin fails++; $display("FAIL reset_flt got %h want 0000", bus.flt_out); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_vectors;
    logic [15:0] vin  [7] = '{16'h0100, 16'h8180, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000, 16'h0280};
    logic [15:0] vexp [7] = '{16'h3C00, 16'hBE00, 16'h57FF, 16'h1C00, 16'h0000, 16'h8000, 16'h4100};
    int          vlat [7] = '{9, 9, 3, 17, 2, 2, 8};
    logic [15:0] res;
    int          lat, bcyc;
    bit          tmo;
    for (int k = 0; k < 7; k++) begin
      convert(vin[k], res, lat, bcyc, tmo);
      tests++; if (tmo) begin fails++; $display("FAIL vec%0d_timeout in=%h no done", k, vin[k]); end
      tests++; if (res !== vexp[k]) begin fails++; $display("FAIL vec%0d_result in=%h got %h want %h", k, vin[k], res, vexp[k]); end
      tests++; if (lat != vlat[k]) begin fails++; $display("FAIL vec%0d_latency in=%h got %0d want %0d", k, vin[k], lat, vlat[k]); end
      tests++; if (bcyc != vlat[k] - 1) begin fails++; $display("FAIL vec%0d_busy in=%h got %0d want %0d", k, vin[k], bcyc, vlat[k] - 1); end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL vec%0d_busy_at_done got %b want 0", k, bus.busy); end
      @(posedge clk); #1;
      tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL vec%0d_done_width got %b want 0", k, bus.done); end
      tests++; if (bus.flt_out !== vexp[k]) begin fails++; $display("FAIL vec%0d_hold got %h want %h", k, bus.flt_out, vexp[k]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] res;
    int          lat, bcyc, n;
    bit          tmo;
    bit          seen;
    // First conversion with a stray start mid-flight.
    @(negedge clk);
    bus.start = 1'b1; bus.fix_in = 16'h0100;
    @(posedge clk); #1;
    lat = 1;
    @(negedge clk);
    bus.start = 1'b0; bus.fix_in = 16'h0000;
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.fix_in = 16'h7FFF;
    @(negedge clk);
    bus.start = 1'b0;
    tmo = 1'b1;
    lat = 1;
    // Re-count from the accepting edge: 1 + 3 negedges elapsed = 4 edges so far.
    lat = 4;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) begin tmo = 1'b0; break; end
    end
    tests++; if (tmo) begin fails++; $display("FAIL b2b_first_timeout no done"); end
    tests++; if (bus.flt_out !== 16'h3C00) begin fails++; $display("FAIL b2b_ignore_result got %h want 3C00", bus.flt_out); end
    tests++; if (lat != 9) begin fails++; $display("FAIL b2b_ignore_latency got %0d want 9", lat); end
    // Start asserted during the done cycle.
    bus.start = 1'b1; bus.fix_in = 16'h7FFF;
    @(posedge clk); #1;
    n = 1;
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_accept_busy got %b want 1", bus.busy); end
    @(negedge clk);
    bus.start = 1'b0; bus.fix_in = 16'h0001;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) begin seen = 1'b1; break; end
    end
    tests++; if (!seen) begin fails++; $display("FAIL b2b_second_timeout no done"); end
    tests++; if (n != 3) begin fails++; $display("FAIL b2b_second_latency got %0d want 3", n); end
    tests++; if (bus.flt_out !== 16'h57FF) begin fails++; $display("FAIL b2b_second_result got %h want 57FF", bus.flt_out); end
    res = '0; bcyc = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    logic [15:0] res;
    int          lat, bcyc;
    bit          tmo;
    bit          saw_done;
    @(negedge clk);
    bus.start = 1'b1; bus.fix_in = 16'h0001;
    @(posedge clk); #1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL abort_done got %b want 0", bus.done); end
    tests++; if (bus.flt_out !== 16'h0000) begin fails++; $display("FAIL abort_flt got %h want 0000", bus.flt_out); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    tests++; if (saw_done) begin fails++; $display("FAIL abort_no_done got activity want none"); end
    convert(16'h0280, res, lat, bcyc, tmo);
    tests++; if (tmo) begin fails++; $display("FAIL abort_after_timeout no done"); end
    tests++; if (res !== 16'h4100) begin fails++; $display("FAIL abort_after_result got %h want 4100", res); end
    tests++; if (lat != 8) begin fails++; $display("FAIL abort_after_latency got %0d want 8", lat); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fix2flt_seq.md
Name: fix2flt_seq

Overview:
- Sequential converter from sign-and-magnitude fixed point to IEEE-754 binary16 (half precision). Inverse of the float-to-fixed program.
- Input is {sign, 15-bit magnitude}, with FRAC_BITS fraction bits (8.8 format by default).
- Normalizes with a one-bit-per-cycle left-shift loop, packs the half-precision word and pulses done.
- Sits beside the float-to-fixed block under the same start/done control, so the two can be run back to back.

Parameters:
- FRAC_BITS, 8, number of fraction bits in the magnitude field; legal range 0..14. Sets exponent bias offset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  request; sampled on rising clk only in IDLE.
- fix_in  input  16  operand: bit15 = sign, bits14:0 = magnitude (value = mag / 2^FRAC_BITS); captured on the accepting edge.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; result valid on flt_out.
- flt_out  output  16  binary16 result {sign, exp[4:0], mant[9:0]}; held until the next PACK.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busy=0; done=0; flt_out=16'h0000; internal sign, mag and shift count cleared.
  - Takes effect immediately, including mid-conversion; the aborted operation produces no done.
- State IDLE:
  - start=1 at an edge: sgn<=fix_in[15], mag<=fix_in[14:0], cnt<=0.
  - Next state is PACK if fix_in[14:0]==0, otherwise NORM.
  - start=0: stay in IDLE.
- State NORM, evaluated each edge:
  - mag[14]==1: go to PACK.
  - Otherwise mag<=mag<<1, cnt<=cnt+1, stay in NORM.
  - cnt never exceeds 14 because mag is nonzero.
- State PACK, one edge:
  - Zero magnitude: flt_out<={sgn,15'b0}. Signed zero is preserved, so 0x8000 maps to 0x8000.
  - Otherwise: exp = 29 - FRAC_BITS - cnt, computed with a 6-bit intermediate; mant = mag[13:4].
  - Bits below mag[4] are truncated; no rounding.
  - With FRAC_BITS=8, exp ranges 7..21, so there is no overflow, underflow or subnormal output.
  - The same edge sets done<=1 and state<=IDLE.
- done:
  - High for exactly the one cycle after the PACK edge (the state is IDLE during that cycle); cleared on the following edge.
  - start asserted during the done cycle is accepted normally, giving back-to-back operation.
- Latency, counted in edges from the accepting start edge to the edge that raises done:
  - Zero magnitude: 2.
  - Nonzero: cnt+3, where cnt = 14 - position of the leading one.
  - Minimum 3 (mag[14] set); maximum 17 (mag=1).
- busy:
  - Rises on the accepting edge; falls on the PACK edge.
  - start while busy is ignored, and fix_in changes while busy have no effect.
- flt_out changes only on a PACK edge or on reset.
- Both signs convert identically; the sign bit passes straight through.

Test Plan:
- fix_in=0x0100 (+1.0) -> flt_out=0x3C00, done 9 edges after start, busy high 8 cycles.
- fix_in=0x8180 (-1.5) -> flt_out=0xBE00, latency 9.
- fix_in=0x7FFF (saturated max) -> flt_out=0x57FF (truncated mantissa 0x3FF), latency 3; then fix_in=0x0001 -> flt_out=0x1C00, latency 17.
- fix_in=0x0000 -> flt_out=0x0000 and fix_in=0x8000 -> flt_out=0x8000, each latency 2.
- Start 0x0100, then re-pulse start with 0x7FFF while busy -> second request ignored, result 0x3C00. Then assert start in the done cycle with 0x7FFF -> accepted, done after 3 further edges, flt_out=0x57FF.
- Start 0x0001, drop reset low at cycle 5 -> immediately busy=0, done=0, flt_out=0x0000, no done pulse. After release, 0x0280 (+2.5) -> flt_out=0x4100.
